// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial sequence detector.
// Latency: n/a (package only).
// Backpressure: n/a.
package seq_det_pkg;

  // Reset pattern of the default 4-bit configuration (oldest bit in the MSB).
  localparam logic [3:0] DEFAULT_PATTERN = 4'b1010;

  // Matching modes for the OVERLAP parameter.
  localparam int MODE_OVERLAP    = 1;
  localparam int MODE_NONOVERLAP = 0;

  // Width needed to hold a pattern length in the range 0..n.
  function automatic int LEN_W(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
// Latency: count reflects inc one clock after the edge that samples it.
// Backpressure: none; inc is accepted every cycle.
// Ports: clk, rst (sync, active-high, clears to 0), inc, count[W-1:0].
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-sequence detector with runtime-loadable pattern/length.
// Latency: z pulses one cycle after the edge sampling the completing bit.
// Backpressure: none; x is consumed only on cycles with en=1.
// Ports: clk, rst (sync, active-high), en, x, load, pat_in[N-1:0],
//        len_in[LEN_W(N)-1:0], z (registered pulse), match_count[CNT_W-1:0].
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = DEFAULT_PATTERN,
  parameter int             OVERLAP = MODE_OVERLAP,
  parameter int             CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  x,
  input  logic                  load,
  input  logic [N-1:0]          pat_in,
  input  logic [LEN_W(N)-1:0]   len_in,
  output logic                  z,
  output logic [CNT_W-1:0]      match_count
);

  localparam int            LW   = LEN_W(N);
  localparam logic [LW-1:0] NMAX = LW'(N);

  logic [N-1:0]  pat_reg;
  logic [N-1:0]  hist;
  logic [N-1:0]  hist_nx;
  logic [LW-1:0] len_reg;
  logic [LW-1:0] fill;
  logic [LW-1:0] fill_nx;
  logic [LW-1:0] len_clamped;
  logic          eq;
  logic          match;
  logic          inc;

  always_comb begin
    // Newest bit enters at bit 0; the oldest bit falls off the top.
    hist_nx     = (hist << 1) | N'(x);
    fill_nx     = (fill >= NMAX) ? NMAX : fill + 1'b1;
    len_clamped = (len_in > NMAX) ? NMAX : len_in;

    // Only the len_reg newest bits take part; higher bits are don't-care.
    eq = 1'b1;
    for (int i = 0; i < N; i++) begin
      if ((LW'(i) < len_reg) && (hist_nx[i] != pat_reg[i])) begin
        eq = 1'b0;
      end
    end

    // fill guards against matching on stale or cleared history bits.
    match = eq && (len_reg != '0) && (fill_nx >= len_reg);
    inc   = !rst && !load && en && match;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_reg <= PATTERN;
      len_reg <= NMAX;
      hist    <= '0;
      fill    <= '0;
      z       <= 1'b0;
    end else if (load) begin
      pat_reg <= pat_in;
      len_reg <= len_clamped;
      hist    <= '0;
      fill    <= '0;
      z       <= 1'b0;
    end else if (en) begin
      hist <= hist_nx;
      z    <= match;
      // Non-overlap mode: the matched window must be refilled entirely.
      if (match && (OVERLAP == MODE_NONOVERLAP)) begin
        fill <= '0;
      end else begin
        fill <= fill_nx;
      end
    end else begin
      z <= 1'b0;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: three detector builds (overlap, non-overlap, 2-bit counter)
// share one stimulus stream; a reference model predicts each z pulse with its
// count, and a negedge monitor checks every observed or missing pulse.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst, en, x, load;
  logic [3:0] pat_in;
  logic [2:0] len_in;
  logic       z0, z1, z2;
  logic [7:0] mc0, mc1;
  logic [1:0] mc2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_detector_param #(.N(4), .PATTERN(4'b1010), .OVERLAP(1), .CNT_W(8)) dut_ovl (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .len_in(len_in), .z(z0), .match_count(mc0));

  seq_detector_param #(.N(4), .PATTERN(4'b1010), .OVERLAP(0), .CNT_W(8)) dut_novl (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .len_in(len_in), .z(z1), .match_count(mc1));

  seq_detector_param #(.N(4), .PATTERN(4'b1010), .OVERLAP(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .len_in(len_in), .z(z2), .match_count(mc2));

  // ---------------- scoreboard ----------------
  typedef struct {
    int dut;
    int cyc;
    int cnt;
  } exp_t;
  exp_t sbq[$];

  function automatic int find_first(input int k);
    foreach (sbq[i]) if (sbq[i].dut == k) return i;
    return -1;
  endfunction

  // ---------------- reference model ----------------
  // Each build keeps the integer value of its last 4 sampled bits and how many
  // bits have arrived since the last clear; a match is the low len bits of the
  // window equal to the low len bits of the pattern.
  int m_pat, m_len;
  int m_win[3], m_seen[3], m_cnt[3];
  int ovl[3]  = '{1, 0, 1};
  int cmax[3] = '{255, 255, 3};

  task automatic model(input logic r, input logic ld, input logic e, input logic xv,
                       input logic [3:0] p, input logic [2:0] l);
    exp_t ent;
    int   m;
    if (r) begin
      m_pat = 10; m_len = 4;
      for (int k = 0; k < 3; k++) begin m_win[k] = 0; m_seen[k] = 0; m_cnt[k] = 0; end
    end else if (ld) begin
      m_pat = int'(p);
      m_len = (int'(l) > 4) ? 4 : int'(l);
      for (int k = 0; k < 3; k++) begin m_win[k] = 0; m_seen[k] = 0; end
    end else if (e) begin
      m = 1 << m_len;
      for (int k = 0; k < 3; k++) begin
        m_win[k] = (m_win[k] * 2 + int'(xv)) % 16;
        if (m_seen[k] < 4) m_seen[k] = m_seen[k] + 1;
        if (m_len != 0 && m_seen[k] >= m_len && (m_win[k] % m) == (m_pat % m)) begin
          if (m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
          ent.dut = k; ent.cyc = cyc + 1; ent.cnt = m_cnt[k];
          sbq.push_back(ent);
          if (ovl[k] == 0) m_seen[k] = 0;
        end
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int   idx;
      logic zk;
      int   ck;
      zk  = (k == 0) ? z0 : (k == 1) ? z1 : z2;
      ck  = (k == 0) ? int'(mc0) : (k == 1) ? int'(mc1) : int'(mc2);
      idx = find_first(k);
      while (idx >= 0 && sbq[idx].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL missed_pulse dut%0d: z=0, required z=1 at cycle %0d", k, sbq[idx].cyc);
        sbq.delete(idx);
        idx = find_first(k);
      end
      if (zk) begin
        checks++;
        if (idx >= 0 && sbq[idx].cyc == cyc) begin
          if (ck != sbq[idx].cnt) begin
            errors++;
            $display("FAIL pulse_count dut%0d cycle %0d: match_count=%0d, required %0d",
                     k, cyc, ck, sbq[idx].cnt);
          end
          sbq.delete(idx);
        end else begin
          errors++;
          $display("FAIL unexpected_pulse dut%0d cycle %0d: z=1, required z=0", k, cyc);
        end
      end else if (idx >= 0 && sbq[idx].cyc == cyc) begin
        checks++; errors++;
        $display("FAIL missed_pulse dut%0d: z=0, required z=1 at cycle %0d", k, cyc);
        sbq.delete(idx);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic r, input logic ld, input logic e, input logic xv,
                      input logic [3:0] p, input logic [2:0] l);
    rst = r; load = ld; en = e; x = xv; pat_in = p; len_in = l;
    model(r, ld, e, xv, p, l);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();                step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0); endtask
  task automatic do_bit(input logic b);     step(1'b0, 1'b0, 1'b1, b, 4'd0, 3'd0); endtask
  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 4'd0, 3'd0);
  endtask
  task automatic do_load(input logic [3:0] p, input logic [2:0] l);
    step(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), p, l);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  logic [14:0] stream = 15'b111101010101011; // bit 0 is sent first

  task automatic send_stream();
    for (int i = 0; i < 15; i++) do_bit(stream[i]);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; load = 1'b0; en = 1'b0; x = 1'b0; pat_in = '0; len_in = '0;

    do_reset(); do_reset();
    chk("reset_z_ovl", int'(z0), 0);
    chk("reset_z_novl", int'(z1), 0);
    chk("reset_z_sat", int'(z2), 0);
    chk("reset_cnt_ovl", int'(mc0), 0);
    chk("reset_cnt_novl", int'(mc1), 0);
    chk("reset_cnt_sat", int'(mc2), 0);

    // Default pattern 1010 over the reference stream.
    send_stream(); do_idle(2);
    chk("stream_cnt_ovl", int'(mc0), 4);
    chk("stream_cnt_novl", int'(mc1), 2);
    chk("stream_cnt_sat", int'(mc2), 3);

    // Loaded 3-bit pattern 111, then a length clamp from 7 down to 4.
    do_reset(); do_load(4'b0111, 3'd3); send_stream(); do_idle(2);
    chk("load3_cnt_ovl", int'(mc0), 2);
    chk("load3_cnt_novl", int'(mc1), 1);
    do_load(4'b1010, 3'd7);
    do_bit(1'b1); do_bit(1'b0); do_bit(1'b1); do_bit(1'b0); do_idle(2);
    chk("clamp_cnt_ovl", int'(mc0), 3);

    // Reset in the middle of a partial match.
    do_reset(); do_bit(1'b1); do_bit(1'b0); do_bit(1'b1);
    do_reset(); do_bit(1'b0);
    do_bit(1'b1); do_bit(1'b0); do_bit(1'b1); do_bit(1'b0); do_idle(2);
    chk("midreset_cnt_ovl", int'(mc0), 1);

    // Enable gaps with random x while disabled.
    do_reset();
    do_bit(1'b1); do_idle(2); do_bit(1'b0); do_idle(2);
    do_bit(1'b1); do_idle(2); do_bit(1'b0); do_idle(2);
    chk("engap_cnt_ovl", int'(mc0), 1);
    chk("engap_cnt_novl", int'(mc1), 1);

    // Randomized traffic with occasional loads and resets.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2)      do_reset();
      else if (r < 7) do_load(4'($urandom), 3'($urandom_range(0, 7)));
      else            step(1'b0, 1'b0, 1'($urandom_range(0, 3) != 0),
                           1'($urandom_range(0, 1)), 4'd0, 3'd0);
    end
    do_idle(2);
    chk("random_cnt_ovl", int'(mc0), m_cnt[0]);
    chk("random_cnt_novl", int'(mc1), m_cnt[1]);
    chk("random_cnt_sat", int'(mc2), m_cnt[2]);

    // Counter saturation, then a disabled detector (length 0).
    do_reset();
    for (int i = 0; i < 6; i++) begin do_bit(1'b1); do_bit(1'b0); end
    do_idle(2);
    chk("sat_cnt_sat", int'(mc2), 3);
    chk("sat_cnt_ovl", int'(mc0), 5);
    do_load(4'b1010, 3'd0);
    for (int i = 0; i < 4; i++) begin do_bit(1'b1); do_bit(1'b0); end
    do_idle(2);
    chk("len0_cnt_sat", int'(mc2), 3);
    chk("len0_cnt_ovl", int'(mc0), 5);

    do_idle(3);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
